// File: rtl/rv_isa_pkg.sv
// RV32I opcode and instruction-class codes shared by the control decoder and the program loader.
// Also holds the signed-range helper used when checking immediates before packing.
package rv_isa_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [2:0] CLS_R     = 3'd0;
  localparam logic [2:0] CLS_I     = 3'd1;
  localparam logic [2:0] CLS_LOAD  = 3'd2;
  localparam logic [2:0] CLS_STORE = 3'd3;
  localparam logic [2:0] CLS_BR    = 3'd4;
  localparam logic [2:0] CLS_JAL   = 3'd5;
  localparam logic [2:0] CLS_LUI   = 3'd6;
  localparam logic [2:0] CLS_SYS   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  // True when v is the sign extension of its low (sign_bit+1) bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned sign_bit);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> sign_bit);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational packer: instruction class plus fields -> RV32I word and an immediate-encodable flag.
// No state, no handshake; the caller decides what to do with a word whose immediate does not fit.
module rv_instr_pack (
  input  logic [2:0]  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        imm_ok
);
  import rv_isa_pkg::*;

  always_comb begin
    word   = '0;
    imm_ok = 1'b0;
    case (cls)
      CLS_R: begin
        word   = {funct7, rs2, rs1, funct3, rd, OP_R};
        imm_ok = 1'b1;
      end
      CLS_I: begin
        word   = {imm[11:0], rs1, funct3, rd, OP_I};
        imm_ok = fits_signed(imm, 11);
      end
      CLS_LOAD: begin
        word   = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        imm_ok = fits_signed(imm, 11);
      end
      CLS_STORE: begin
        word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        imm_ok = fits_signed(imm, 11);
      end
      CLS_BR: begin
        word   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BR};
        imm_ok = fits_signed(imm, 12) && !imm[0];
      end
      CLS_JAL: begin
        word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        imm_ok = fits_signed(imm, 20) && !imm[0];
      end
      CLS_LUI: begin
        word   = {imm[31:12], rd, OP_LUI};
        imm_ok = (imm[11:0] == 12'd0);
      end
      default: begin
        // system: rd, rs1 and funct3 are forced to zero (ecall/ebreak only)
        word   = {imm[11:0], 5'd0, 3'd0, 5'd0, OP_SYS};
        imm_ok = (imm[31:1] == 31'd0);
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: packs instruction beats and writes them to imem at sequential addresses, one per cycle.
// Accepted beat appears on the imem port one cycle later; in_ready drops outside LOAD or once DEPTH words are written.
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);
  import rv_isa_pkg::*;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              fin_q, fin_d;
  logic              done_q, done_d;
  logic              accept;
  logic [31:0]       pk_word;
  logic              pk_ok;

  rv_instr_pack u_pack (
    .cls    (in_class),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .word   (pk_word),
    .imm_ok (pk_ok)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      waddr_q <= '0;
      count_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      fin_q   <= fin_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        // Session ends on a final beat (even if rejected) or on the write that fills DEPTH.
        if (accept && (in_last || (pk_ok && (count_q + CNT_ONE) == DEPTH_L))) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        if (start) state_d = ST_LOAD;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q == ST_LOAD);
    in_ready = (state_q == ST_LOAD) && (count_q < DEPTH_L);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    addr_d  = addr_q;
    waddr_d = waddr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    we_d    = 1'b0;
    // done trails the final write by one cycle so the two never overlap
    done_d  = fin_q;
    fin_d   = (state_q == ST_LOAD) && (state_d == ST_DONE);
    if (state_q != ST_LOAD && start) begin
      addr_d  = BASE_L;
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      if (pk_ok) begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = pk_word;
        addr_d  = addr_q + ADR_ONE;
        count_d = count_q + CNT_ONE;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed RV32I encodings plus random sessions against a cycle model.
// DUT uses DEPTH=4 and BASE_ADDR=1022 so session limits and address wrap are exercised constantly.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 10;
  localparam int BASE   = 1022;
  localparam int DEPTH  = 4;

  typedef struct {
    bit [2:0] cls;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [2:0] f3;
    bit [6:0] f7;
    int       imm;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [2:0]        in_class = '0;
  logic [4:0]        in_rd = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic [2:0]        in_funct3 = '0;
  logic [6:0]        in_funct7 = '0;
  logic [31:0]       in_imm = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;

  // reference model state: 0 idle, 1 load, 2 done
  int m_st = 0;
  int m_addr = 0;
  int m_cnt = 0;
  bit m_err = 1'b0;
  bit fin_prev = 1'b0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input int cls, input int rd, input int rs1, input int rs2,
                               input int f3, input int f7, input int imm);
    beat_t b;
    b.cls = 3'(cls); b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2);
    b.f3 = 3'(f3); b.f7 = 7'(f7); b.imm = imm;
    return b;
  endfunction

  // RV32I field placement written from the instruction formats with integer arithmetic.
  task automatic ref_enc(input beat_t b, output bit ok, output bit [31:0] w);
    int rd, rs1, rs2, f3, f7, imm;
    rd = int'(b.rd); rs1 = int'(b.rs1); rs2 = int'(b.rs2);
    f3 = int'(b.f3); f7 = int'(b.f7); imm = b.imm;
    ok = 1'b1;
    w  = '0;
    case (b.cls)
      3'd0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
      3'd1, 3'd2: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | ((b.cls == 3'd1) ? 'h13 : 'h03);
      end
      3'd3: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm & 'h1F) << 7) | 'h23;
      end
      3'd4: begin
        ok = (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
        w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
           | (f3 << 12) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
      end
      3'd5: begin
        ok = (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
        w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) | (((imm >> 11) & 1) << 20)
           | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
      end
      3'd6: begin
        ok = ((imm & 'hFFF) == 0);
        w  = (imm & 'hFFFFF000) | (rd << 7) | 'h37;
      end
      default: begin
        ok = (imm == 0) || (imm == 1);
        w  = ((imm & 'hFFF) << 20) | 'h73;
      end
    endcase
  endtask

  // One clock: drive inputs, advance the model across the edge, compare all outputs after it.
  task automatic cyc(input bit rn, input bit st, input bit vld, input bit last, input beat_t b);
    bit rdy, ok, n_we, n_fin, e_done;
    bit [31:0] w;
    int n_addr;
    rst_n = rn; start = st; in_valid = vld; in_last = last;
    in_class = b.cls; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
    in_funct3 = b.f3; in_funct7 = b.f7; in_imm = b.imm;
    rdy = (m_st == 1) && (m_cnt < DEPTH);
    n_we = 1'b0; n_fin = 1'b0; n_addr = 0; w = '0; e_done = 1'b0;
    if (!rn) begin
      m_st = 0; m_addr = 0; m_cnt = 0; m_err = 1'b0; fin_prev = 1'b0;
    end else begin
      e_done = fin_prev;
      if (m_st != 1 && st) begin
        m_st = 1; m_addr = BASE; m_cnt = 0; m_err = 1'b0;
      end else if (vld && rdy) begin
        ref_enc(b, ok, w);
        if (ok) begin
          n_we = 1'b1; n_addr = m_addr;
          m_addr = (m_addr + 1) % (1 << ADDR_W);
          m_cnt++;
        end else begin
          m_err = 1'b1;
        end
        if (last || m_cnt == DEPTH) begin
          m_st = 2; n_fin = 1'b1;
        end
      end
      fin_prev = n_fin;
    end
    @(posedge clk);
    @(negedge clk);
    check("imem_we", 32'(imem_we), 32'(n_we));
    if (n_we) begin
      check("imem_addr", 32'(imem_addr), 32'(n_addr));
      check("imem_wdata", imem_wdata, w);
    end
    check("done", 32'(done), 32'(e_done));
    check("busy", 32'(busy), 32'(m_st == 1));
    check("count", 32'(count), 32'(m_cnt));
    check("err", 32'(err), 32'(m_err));
    check("in_ready", 32'(in_ready), 32'((m_st == 1) && (m_cnt < DEPTH)));
    if (imem_we) wr_seen++;
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    int edges[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                      -1048576, 1048574, 1048576, -1048578};
    b = mk($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127), 0);
    case ($urandom_range(0, 4))
      0: b.imm = int'($urandom_range(0, 8192)) - 4096;
      1: b.imm = int'($urandom_range(0, 4194304)) - 2097152;
      2: b.imm = int'($urandom);
      3: b.imm = int'($urandom) & 'hFFFFF000;
      default: b.imm = edges[$urandom_range(0, 11)];
    endcase
    if (b.cls == 3'd7 && $urandom_range(0, 1) == 1) b.imm = int'($urandom_range(0, 2));
    return b;
  endfunction

  initial begin
    beat_t nb;
    int w0;
    nb = mk(0, 0, 0, 0, 0, 0, 0);

    // reset state
    cyc(0, 0, 0, 0, nb);
    cyc(0, 1, 0, 0, nb);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);

    // R, I, store, branch; the fourth write fills DEPTH and wraps the address
    cyc(1, 1, 0, 0, nb);
    cyc(1, 0, 1, 0, mk(0, 3, 1, 2, 0, 0, 0));
    check("R_word", imem_wdata, 32'h002081B3);
    check("R_addr", 32'(imem_addr), 32'(BASE));
    cyc(1, 0, 1, 0, mk(1, 1, 0, 0, 0, 0, 5));
    check("I_word", imem_wdata, 32'h00500093);
    cyc(1, 0, 1, 0, mk(3, 0, 1, 2, 3, 0, 8));
    check("S_word", imem_wdata, 32'h0020B423);
    check("S_wrap_addr", 32'(imem_addr), 32'd0);
    cyc(1, 0, 1, 0, mk(4, 0, 1, 2, 0, 0, -4));
    check("B_word", imem_wdata, 32'hFE208EE3);
    cyc(1, 0, 0, 0, nb);
    cyc(1, 0, 0, 0, nb);

    // jal then ecall with in_last
    cyc(1, 1, 0, 0, nb);
    cyc(1, 0, 1, 0, mk(5, 1, 0, 0, 0, 0, 8));
    check("J_word", imem_wdata, 32'h008000EF);
    cyc(1, 0, 1, 1, mk(7, 0, 0, 0, 0, 0, 0));
    check("ecall_word", imem_wdata, 32'h00000073);
    check("ecall_no_done_yet", 32'(done), 32'd0);
    cyc(1, 0, 0, 0, nb);
    check("ecall_done", 32'(done), 32'd1);
    check("ecall_count", 32'(count), 32'd2);

    // rejected branch: no write, err sticks, next beat reuses the address
    cyc(1, 1, 0, 0, nb);
    cyc(1, 0, 1, 0, mk(4, 0, 1, 2, 0, 0, 3));
    check("rej_we", 32'(imem_we), 32'd0);
    check("rej_err", 32'(err), 32'd1);
    cyc(1, 0, 1, 1, mk(1, 2, 3, 0, 0, 0, -1));
    check("rej_next_addr", 32'(imem_addr), 32'(BASE));
    cyc(1, 0, 0, 0, nb);

    // six beats offered against DEPTH=4
    cyc(1, 1, 0, 0, nb);
    w0 = wr_seen;
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, mk(1, i, 1, 0, 0, 0, i));
    check("depth_writes", 32'(wr_seen - w0), 32'd4);
    check("depth_ready", 32'(in_ready), 32'd0);
    check("depth_count", 32'(count), 32'd4);

    // reset mid-stream
    cyc(1, 1, 0, 0, nb);
    cyc(1, 0, 1, 0, mk(1, 1, 1, 0, 0, 0, 1));
    cyc(0, 0, 1, 0, mk(1, 1, 1, 0, 0, 0, 2));
    check("midrst_we", 32'(imem_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);

    // random sessions with gaps, stray starts and occasional resets
    for (int s = 0; s < 80; s++) begin
      int nbeats;
      nbeats = $urandom_range(1, 7);
      cyc(1, 1, 0, 0, nb);
      for (int i = 0; i < nbeats; i++) begin
        if ($urandom_range(0, 3) == 0) cyc(1, 0, 0, 0, nb);
        cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0), 1'b1,
            (i == nbeats - 1), rand_beat());
      end
      cyc(1, 0, 0, 0, nb);
      cyc(1, 0, 0, 0, nb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
